// File: rtl/rc_servo_pkg.sv
// Shared constants and FSM encoding for the RC servo pulse capture path.
package rc_servo_pkg;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_WAIT_LOW  = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2
    } cap_state_e;

    localparam int unsigned DEF_CLK_PER_US    = 10;
    localparam int unsigned DEF_MIN_US        = 1000;
    localparam int unsigned DEF_MAX_US        = 2000;
    localparam int unsigned DEF_ACCEPT_MIN_US = 800;
    localparam int unsigned DEF_ACCEPT_MAX_US = 2200;
    localparam int unsigned DEF_LOST_US       = 25000;
    localparam int unsigned POS_CENTRE        = 500;

    localparam int unsigned WIDTH_W = 12;
    localparam int unsigned LOSS_W  = 15;
    localparam int unsigned POS_W   = 10;

endpackage

// File: rtl/rc_sync_edge.sv
// Two-flop synchronizer with registered rise/fall detection.
// ready_o marks when the pipeline holds only post-reset samples, so the
// reset value of the flops is never mistaken for a real input level or edge.
module rc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic ready_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [2:0] fill_q;
    logic       rise_q;
    logic       fall_q;

    // Synchronize, keep a delayed copy, and register the decoded edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 3'b000;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fill_q <= {fill_q[1:0], 1'b1};
            rise_q <= fill_q[2] & sync_q & ~prev_q;
            fall_q <= fill_q[2] & ~sync_q & prev_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign ready_o = fill_q[2];

endmodule

// File: rtl/rc_pwm_capture.sv
// RC servo pulse decoder: measures high width in microseconds, converts it to
// a clamped 10-bit position, flags malformed pulses and loss of signal.
module rc_pwm_capture
    import rc_servo_pkg::*;
#(
    parameter int unsigned CLK_PER_US    = DEF_CLK_PER_US,
    parameter int unsigned MIN_US        = DEF_MIN_US,
    parameter int unsigned MAX_US        = DEF_MAX_US,
    parameter int unsigned ACCEPT_MIN_US = DEF_ACCEPT_MIN_US,
    parameter int unsigned ACCEPT_MAX_US = DEF_ACCEPT_MAX_US,
    parameter int unsigned LOST_US       = DEF_LOST_US
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_async_i,
    output logic [POS_W-1:0] pos_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             lost_o
);

    localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0]   PRE_TC    = PRE_W'(CLK_PER_US - 1);
    localparam logic [WIDTH_W-1:0] MIN_C     = WIDTH_W'(MIN_US);
    localparam logic [WIDTH_W-1:0] MAX_C     = WIDTH_W'(MAX_US);
    localparam logic [WIDTH_W-1:0] ACC_MIN_C = WIDTH_W'(ACCEPT_MIN_US);
    localparam logic [WIDTH_W-1:0] ACC_MAX_C = WIDTH_W'(ACCEPT_MAX_US);
    localparam logic [POS_W-1:0]   SPAN_C    = POS_W'(MAX_US - MIN_US);
    localparam logic [POS_W-1:0]   POS_RST   = POS_W'(POS_CENTRE);
    localparam logic [LOSS_W-1:0]  LOST_C    = LOSS_W'(LOST_US);

    logic sig_level;
    logic sig_rise;
    logic sig_fall;
    logic sig_ready;

    cap_state_e         state_q, state_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               lost_q, lost_d;
    logic               us_tick_c;
    logic [WIDTH_W-1:0] width_eff_c;

    // Compare before subtracting so the 12-bit difference never wraps.
    function automatic logic [POS_W-1:0] clamp_pos(input logic [WIDTH_W-1:0] w);
        if (w < MIN_C) begin
            return '0;
        end else if (w > MAX_C) begin
            return SPAN_C;
        end else begin
            return POS_W'(w - MIN_C);
        end
    endfunction

    rc_sync_edge u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (pwm_async_i),
        .level_o (sig_level),
        .rise_o  (sig_rise),
        .fall_o  (sig_fall),
        .ready_o (sig_ready)
    );

    // Microsecond prescaler, realigned to every detected rise.
    always_comb begin
        us_tick_c = (presc_q == PRE_TC);
        presc_d   = presc_q + PRE_W'(1);
        if (sig_rise || us_tick_c) begin
            presc_d = '0;
        end
    end

    // Width including this cycle's tick, saturating at full scale.
    always_comb begin
        width_eff_c = width_q;
        if (us_tick_c && (width_q != '1)) begin
            width_eff_c = width_q + WIDTH_W'(1);
        end
    end

    // Capture FSM: next state, width counter, position and strobes.
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        pos_d   = pos_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_WAIT_LOW: begin
                if (sig_ready && !sig_level) begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (sig_rise) begin
                    state_d = ST_HIGH;
                    width_d = '0;
                end
            end
            ST_HIGH: begin
                if (sig_fall) begin
                    state_d = ST_WAIT_RISE;
                    if ((width_eff_c >= ACC_MIN_C) && (width_eff_c <= ACC_MAX_C)) begin
                        valid_d = 1'b1;
                        pos_d   = clamp_pos(width_eff_c);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (width_q > ACC_MAX_C) begin
                    // Stuck high: report once, then require a low before re-arming.
                    state_d = ST_WAIT_LOW;
                    err_d   = 1'b1;
                end else begin
                    width_d = width_eff_c;
                end
            end
            default: begin
                state_d = ST_WAIT_LOW;
            end
        endcase
    end

    // Loss-of-signal timer; a valid pulse on the expiry cycle wins.
    always_comb begin
        loss_d = loss_q;
        lost_d = lost_q;
        if (valid_d) begin
            loss_d = '0;
            lost_d = 1'b0;
        end else begin
            if (us_tick_c && (loss_q < LOST_C)) begin
                loss_d = loss_q + LOSS_W'(1);
            end
            if (loss_q >= LOST_C) begin
                lost_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOW;
            presc_q <= '0;
            width_q <= '0;
            loss_q  <= '0;
            pos_q   <= POS_RST;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            width_q <= width_d;
            loss_q  <= loss_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    assign pos_o   = pos_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign lost_o  = lost_q;

endmodule

// File: tb/tb_rc_pwm_capture.sv
// Directed testbench for rc_pwm_capture (short loss timeout to keep runs brief).
module tb_rc_pwm_capture;

    localparam int CPU  = 2;
    localparam int LOST = 4000;

    logic       clk;
    logic       rst_n;
    logic       pwm;
    logic [9:0] pos;
    logic       valid;
    logic       err;
    logic       lost;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;
    int lost_rise_cyc = 0;
    logic lost_prev = 1'b1;

    rc_pwm_capture #(
        .CLK_PER_US (CPU),
        .LOST_US    (LOST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_async_i (pwm),
        .pos_o       (pos),
        .valid_o     (valid),
        .err_o       (err),
        .lost_o      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe observer sampling away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (err === 1'b1) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (valid === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
        if (lost === 1'b1 && lost_prev !== 1'b1) lost_rise_cyc <= cyc;
        lost_prev <= lost;
    end

    task automatic wait_us(input int us);
        repeat (us * CPU) @(negedge clk);
    endtask

    // Low gap, then a high pulse of hi_us, then time for the result to land.
    task automatic pulse(input int hi_us);
        pwm = 1'b0;
        wait_us(100);
        pwm = 1'b1;
        wait_us(hi_us);
        pwm = 1'b0;
        wait_us(20);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (pos !== 10'd500) begin n_fail++; $display("FAIL reset_pos: got %0d expected 500", pos); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (lost !== 1'b1) begin n_fail++; $display("FAIL reset_lost: got %b expected 1", lost); end
        rst_n = 1'b1;
        wait_us(10);
    endtask

    task automatic test_nominal;
        for (int f = 0; f < 3; f++) begin
            int v0 = valid_cnt;
            int e0 = err_cnt;
            pwm = 1'b0;
            wait_us(100);
            pwm = 1'b1;
            wait_us(1500);
            if (f == 0) begin
                n_checks++; if (lost !== 1'b1) begin n_fail++; $display("FAIL nominal_lost_before: got %b expected 1", lost); end
            end
            pwm = 1'b0;
            wait_us(20);
            n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL nominal_valid f%0d: got %0d strobes expected 1", f, valid_cnt - v0); end
            n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL nominal_err f%0d: got %0d strobes expected 0", f, err_cnt - e0); end
            n_checks++; if (pos < 10'd499 || pos > 10'd501) begin n_fail++; $display("FAIL nominal_pos f%0d: got %0d expected 499..501", f, pos); end
            n_checks++; if (lost !== 1'b0) begin n_fail++; $display("FAIL nominal_lost f%0d: got %b expected 0", f, lost); end
        end
    endtask

    task automatic test_clamp;
        int v0 = valid_cnt;
        pulse(900);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL clamp_low_valid: got %0d expected 1", valid_cnt - v0); end
        n_checks++; if (pos !== 10'd0) begin n_fail++; $display("FAIL clamp_low_pos: got %0d expected 0", pos); end
        v0 = valid_cnt;
        pulse(2100);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL clamp_high_valid: got %0d expected 1", valid_cnt - v0); end
        n_checks++; if (pos !== 10'd1000) begin n_fail++; $display("FAIL clamp_high_pos: got %0d expected 1000", pos); end
    endtask

    task automatic test_short;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        logic [9:0] p0 = pos;
        pulse(500);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL short_err: got %0d expected 1", err_cnt - e0); end
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL short_valid: got %0d expected 0", valid_cnt - v0); end
        n_checks++; if (pos !== p0) begin n_fail++; $display("FAIL short_pos: got %0d expected %0d", pos, p0); end
    endtask

    task automatic test_stuck_high;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        int t0;
        int d;
        pwm = 1'b0;
        wait_us(100);
        pwm = 1'b1;
        t0 = cyc;
        wait_us(2500);
        d = last_err_cyc - t0;
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL stuck_err: got %0d expected 1", err_cnt - e0); end
        n_checks++; if (d < 2200 * CPU || d > 2203 * CPU + 6) begin n_fail++; $display("FAIL stuck_err_time: got %0d cycles expected %0d..%0d", d, 2200 * CPU, 2203 * CPU + 6); end
        pwm = 1'b0;
        wait_us(20);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL stuck_fall_err: got %0d expected 1", err_cnt - e0); end
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL stuck_fall_valid: got %0d expected 0", valid_cnt - v0); end
        pulse(1200);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL stuck_next_valid: got %0d expected 1", valid_cnt - v0); end
        n_checks++; if (pos < 10'd199 || pos > 10'd201) begin n_fail++; $display("FAIL stuck_next_pos: got %0d expected 199..201", pos); end
    endtask

    task automatic test_high_at_reset;
        int v0;
        int e0;
        pwm   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_us(700);
        pwm = 1'b0;
        wait_us(100);
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL partial_valid: got %0d expected 0", valid_cnt - v0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL partial_err: got %0d expected 0", err_cnt - e0); end
        pulse(1800);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL partial_next_valid: got %0d expected 1", valid_cnt - v0); end
        n_checks++; if (pos < 10'd799 || pos > 10'd801) begin n_fail++; $display("FAIL partial_next_pos: got %0d expected 799..801", pos); end
    endtask

    task automatic test_loss;
        logic [9:0] p0;
        int d;
        pulse(1500);
        p0 = pos;
        n_checks++; if (lost !== 1'b0) begin n_fail++; $display("FAIL loss_before: got %b expected 0", lost); end
        wait_us(LOST + 50);
        d = lost_rise_cyc - last_valid_cyc;
        n_checks++; if (lost !== 1'b1) begin n_fail++; $display("FAIL loss_set: got %b expected 1", lost); end
        n_checks++; if (d < LOST * CPU - 4 || d > LOST * CPU + 6) begin n_fail++; $display("FAIL loss_time: got %0d cycles expected %0d..%0d", d, LOST * CPU - 4, LOST * CPU + 6); end
        n_checks++; if (pos !== p0) begin n_fail++; $display("FAIL loss_pos_hold: got %0d expected %0d", pos, p0); end
        pulse(1000);
        n_checks++; if (lost !== 1'b0) begin n_fail++; $display("FAIL loss_clear: got %b expected 0", lost); end
        n_checks++; if (pos !== 10'd0) begin n_fail++; $display("FAIL loss_next_pos: got %0d expected 0", pos); end
    endtask

    task automatic test_reset_mid_pulse;
        int v0 = valid_cnt;
        int e0 = err_cnt;
        pwm = 1'b0;
        wait_us(100);
        pwm = 1'b1;
        wait_us(750);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (pos !== 10'd500) begin n_fail++; $display("FAIL midrst_pos: got %0d expected 500", pos); end
        n_checks++; if (lost !== 1'b1) begin n_fail++; $display("FAIL midrst_lost: got %b expected 1", lost); end
        n_checks++; if (valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_strobes: got valid=%b err=%b expected 0 0", valid, err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_us(750);
        pwm = 1'b0;
        wait_us(100);
        n_checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midrst_no_strobe: got valid=%0d err=%0d expected 0 0", valid_cnt - v0, err_cnt - e0); end
        pulse(1500);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_cnt - v0); end
        n_checks++; if (pos < 10'd499 || pos > 10'd501) begin n_fail++; $display("FAIL midrst_next_pos: got %0d expected 499..501", pos); end
        n_checks++; if (lost !== 1'b0) begin n_fail++; $display("FAIL midrst_next_lost: got %b expected 0", lost); end
    endtask

    task automatic test_no_overlap;
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_clamp;
        test_short;
        test_stuck_high;
        test_high_at_reset;
        test_loss;
        test_reset_mid_pulse;
        test_no_overlap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
